hpdmc_rdcapture: RTL and testbench
==================================

HPDMC_RDCAPTURE -- requirements
Module: hpdmc_rdcapture

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, output FIFO depth in 64-bit entries (power of two, 4..32).
REQ-002 Parameter BURST_BEATS, default 4, number of sys_clk cycles of read data per READ command.
REQ-003 sys_clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 sys_rst_n  in  1  reset, asynchronous, active-low.
REQ-005 read_issue  in  1  single-cycle pulse: a READ command is on the DRAM bus this cycle.
REQ-006 rd_lat  in  3  cycles from read_issue to the first valid IDDR beat, 1..7; 0 is treated as 1.
REQ-007 q1  in  32  rising-edge data from the 32-bit IDDR bank (SAME_EDGE_PIPELINED).
REQ-008 q2  in  32  falling-edge data from the same IDDR bank.
REQ-009 out_data  out  64  head FIFO entry, {q1,q2}, with q1 in bits 63:32.
REQ-010 out_valid  out  1  out_data holds a valid entry.
REQ-011 out_ready  in  1  consumer accepts out_data this cycle.
REQ-012 overflow  out  1  sticky: a beat was dropped because the FIFO was full.
REQ-013 ovf_clr  in  1  single-cycle clear of overflow.
REQ-014 beat_count  out  16  captured-beat statistic (see Configuration).

Function
REQ-015 Capture window: cycle n SHALL be a capture cycle iff read_issue was high in any cycle n-L-(BURST_BEATS-1) .. n-L, where L = effective rd_lat; implemented with an issue-history shift register.
REQ-016 Overlapping or back-to-back windows SHALL OR together; no beat duplicated or skipped.
REQ-017 rd_lat changes SHALL take effect for issues after the change; in-flight windows use the new value (software changes rd_lat only when idle).
REQ-018 On each capture cycle, {q1,q2} SHALL be written to the FIFO at that cycle's closing edge if not full.
REQ-019 Write latency: beat written at edge E SHALL appear on out_data with out_valid=1 in the cycle after E if the FIFO was empty (first-word-fall-through, registered head).
REQ-020 Pop: out_valid & out_ready at an edge SHALL advance the head; next entry, if any, is presented the following cycle without bubble.
REQ-021 out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-022 Full with simultaneous pop and capture: the write SHALL be accepted; no overflow.
REQ-023 Full without pop on a capture cycle: beat SHALL be dropped and overflow set at that edge.
REQ-024 ovf_clr clears overflow; simultaneous set and ovf_clr: set SHALL win.
REQ-025 Empty with simultaneous write and out_ready: out_ready SHALL be ignored (out_valid was 0); entry presented next cycle.
REQ-026 Read/write pointers SHALL wrap modulo FIFO_DEPTH; full/empty distinguished by an extra pointer bit.

Reset
REQ-027 sys_rst_n low SHALL immediately clear issue history, pointers, overflow, beat_count; out_valid=0, out_data=0.
REQ-028 Reset mid-burst SHALL discard all pending and buffered beats; no beat from a pre-reset issue is captured after release.
REQ-029 FIFO storage array SHALL NOT require reset.

Configuration
REQ-030 Macro HPDMC_RDSTAT_EN defined: beat_count SHALL increment by 1 per beat written into the FIFO (dropped beats excluded), wrapping 0xFFFF -> 0x0000.
REQ-031 Macro HPDMC_RDSTAT_EN undefined: beat_count SHALL be constant 0 and no counter logic synthesized; all other behaviour identical.

Verification
REQ-032 rd_lat=3, read_issue at cycle 10, q1/q2 = beat index k in 10+3..10+6 -> four entries {k,k'} in order, first out_valid at cycle 14, beat_count=4.
REQ-033 rd_lat=2, issues at cycles 0 and 4 (back-to-back), out_ready=1 -> 8 contiguous entries, no gap, no duplicates.
REQ-034 out_ready=0, three issues (12 beats), FIFO_DEPTH=8 -> 8 entries held, overflow=1 at 9th beat edge, beat_count=8; then ovf_clr -> overflow=0.
REQ-035 FIFO full, out_ready=1 during a capture cycle -> write accepted, overflow stays 0, order preserved.
REQ-036 sys_rst_n low for 1 cycle during 2nd beat of a burst -> out_valid=0 immediately, remaining beats not captured, beat_count=0.
REQ-037 rd_lat=0 -> behaves exactly as rd_lat=1.

Source files
------------

// File: rtl/hpdmc_rdcapture.sv
`default_nettype none
// ============================================================================
//  Module   : hpdmc_rdcapture
//  Purpose  : Read-data capture for the HPDMC SDRAM controller. Tracks READ
//             commands in an issue-history shift register, opens a capture
//             window of BURST_BEATS cycles starting rd_lat cycles after each
//             issue, and pushes {q1,q2} from the IDDR bank into a
//             first-word-fall-through FIFO with a registered head.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    FIFO_DEPTH  : FIFO depth in 64-bit entries (power of two, 4..32)
//    BURST_BEATS : sys_clk cycles of read data per READ command
//  Ports
//    sys_clk     in   clock, all state changes on rising edge
//    sys_rst_n   in   asynchronous active-low reset
//    read_issue  in   pulse: READ command on the DRAM bus this cycle
//    rd_lat[2:0] in   issue-to-first-beat latency, 0 is treated as 1
//    q1[31:0]    in   rising-edge IDDR data
//    q2[31:0]    in   falling-edge IDDR data
//    out_data    out  head FIFO entry {q1,q2}
//    out_valid   out  out_data holds a valid entry
//    out_ready   in   consumer accepts out_data this cycle
//    overflow    out  sticky: a beat was dropped because the FIFO was full
//    ovf_clr     in   pulse: clear overflow (a simultaneous set wins)
//    beat_count  out  number of beats written into the FIFO (mod 2^16)
//  Configuration
//    HPDMC_RDSTAT_EN : when defined, beat_count is a live counter; when
//                      undefined, beat_count is tied to zero.
// ============================================================================
module hpdmc_rdcapture #(
   parameter int FIFO_DEPTH  = 8,
   parameter int BURST_BEATS = 4
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic        read_issue,
   input  logic [2:0]  rd_lat,
   input  logic [31:0] q1,
   input  logic [31:0] q2,
   output logic [63:0] out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        overflow,
   input  logic        ovf_clr,
   output logic [15:0] beat_count
);

   localparam int c_AW     = $clog2(FIFO_DEPTH);
   // History must reach back to the oldest issue that can still own a beat:
   // maximum latency 7 plus BURST_BEATS-1 further cycles.
   localparam int c_HIST_W = BURST_BEATS + 6;

   // ------------------------------------------------------------------------
   // Declarations
   // ------------------------------------------------------------------------
   logic [c_HIST_W-1:0] r_hist;        // r_hist[k] = read_issue k+1 cycles ago
   logic [2:0]          w_lat;
   logic                w_capture;

   logic [63:0]         r_mem [FIFO_DEPTH];
   logic [c_AW:0]       r_wr_ptr;
   logic [c_AW:0]       r_rd_ptr;
   logic [c_AW:0]       w_wr_ptr_nxt;
   logic [c_AW:0]       w_rd_ptr_nxt;
   logic                w_full;
   logic                w_pop;
   logic                w_push;
   logic                w_drop;
   logic                w_nxt_valid;
   logic [63:0]         w_wdata;
   logic [63:0]         w_nxt_head;

   logic                r_out_valid;
   logic [63:0]         r_out_data;
   logic                r_overflow;

   // ------------------------------------------------------------------------
   // Capture window
   // ------------------------------------------------------------------------
   assign w_lat = (rd_lat == 3'd0) ? 3'd1 : rd_lat;

   // Cycle n captures if an issue occurred j cycles ago for any j in
   // [L, L+BURST_BEATS-1]. Since L >= 1 the current read_issue never
   // contributes, so the window is driven purely from registered history.
   // Overlapping windows simply OR, so each cycle yields at most one beat.
   always_comb begin
      w_capture = 1'b0;
      for (int j = 1; j <= c_HIST_W; j++) begin
         if ((j >= int'(w_lat)) && (j < int'(w_lat) + BURST_BEATS)) begin
            w_capture = w_capture | r_hist[j-1];
         end
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_hist <= '0;
      end else begin
         r_hist <= {r_hist[c_HIST_W-2:0], read_issue};
      end
   end

   // ------------------------------------------------------------------------
   // FIFO control
   // ------------------------------------------------------------------------
   assign w_wdata = {q1, q2};

   // Extra pointer MSB distinguishes full from empty when the low bits match.
   assign w_full = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                   (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);

   // out_valid mirrors "FIFO not empty", so out_ready while empty is ignored.
   assign w_pop  = r_out_valid & out_ready;
   // A pop on the same edge frees the slot, so a full FIFO still accepts.
   assign w_push = w_capture & (~w_full | w_pop);
   assign w_drop = w_capture & w_full & ~w_pop;

   assign w_wr_ptr_nxt = r_wr_ptr + {{c_AW{1'b0}}, w_push};
   assign w_rd_ptr_nxt = r_rd_ptr + {{c_AW{1'b0}}, w_pop};
   assign w_nxt_valid  = (w_wr_ptr_nxt != w_rd_ptr_nxt);

   // Next head: if the entry that becomes the head is the one being written
   // on this edge (FIFO empty, or draining its last entry), bypass the array.
   assign w_nxt_head = (w_push && (w_rd_ptr_nxt == r_wr_ptr))
                       ? w_wdata
                       : r_mem[w_rd_ptr_nxt[c_AW-1:0]];

   // Storage array carries no reset; only written slots are ever presented.
   always_ff @(posedge sys_clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr[c_AW-1:0]] <= w_wdata;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
      end else begin
         r_wr_ptr    <= w_wr_ptr_nxt;
         r_rd_ptr    <= w_rd_ptr_nxt;
         r_out_valid <= w_nxt_valid;
         // Without a pop the head slot is never overwritten, so the
         // reloaded value equals the current one and out_data stays stable.
         if (w_nxt_valid) begin
            r_out_data <= w_nxt_head;
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;

   // ------------------------------------------------------------------------
   // Sticky overflow; a drop on the same edge as ovf_clr keeps it set.
   // ------------------------------------------------------------------------
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_overflow <= 1'b0;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
      end else if (ovf_clr) begin
         r_overflow <= 1'b0;
      end
   end

   assign overflow = r_overflow;

   // ------------------------------------------------------------------------
   // Captured-beat statistic
   // ------------------------------------------------------------------------
`ifdef HPDMC_RDSTAT_EN
   logic [15:0] r_beat_count;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_beat_count <= 16'd0;
      end else if (w_push) begin
         r_beat_count <= r_beat_count + 16'd1;
      end
   end

   assign beat_count = r_beat_count;
`else
   assign beat_count = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hpdmc_rdcapture.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hpdmc_rdcapture
//  Purpose  : Self-checking bench for hpdmc_rdcapture. A queue-based model
//             derives capture cycles from the list of past issue times and
//             tracks FIFO contents, overflow and beat count; every cycle the
//             DUT outputs are compared against it. Directed sequences and a
//             latency table cover the multi-cycle corner cases.
//  Revision : 1.0  initial release
// ============================================================================
module tb_hpdmc_rdcapture;

   localparam int D = 8;
   localparam int B = 4;

   logic        sys_clk = 1'b0;
   logic        sys_rst_n = 1'b0;
   logic        read_issue = 1'b0;
   logic [2:0]  rd_lat = 3'd1;
   logic [31:0] q1 = 32'd0;
   logic [31:0] q2 = 32'd0;
   logic [63:0] out_data;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic        overflow;
   logic        ovf_clr = 1'b0;
   logic [15:0] beat_count;

   hpdmc_rdcapture #(.FIFO_DEPTH(D), .BURST_BEATS(B)) dut (
      .sys_clk    (sys_clk),
      .sys_rst_n  (sys_rst_n),
      .read_issue (read_issue),
      .rd_lat     (rd_lat),
      .q1         (q1),
      .q2         (q2),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .overflow   (overflow),
      .ovf_clr    (ovf_clr),
      .beat_count (beat_count)
   );

   always #5 sys_clk = ~sys_clk;

   int n_pass  = 0;
   int n_total = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) begin
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   function automatic logic [15:0] exp_cnt(input int c);
`ifdef HPDMC_RDSTAT_EN
      return 16'(c);
`else
      return 16'd0;
`endif
   endfunction

   // ------------------------------------------------------------------------
   // Reference model: evaluated at every falling edge (inputs are stable).
   // ------------------------------------------------------------------------
   int          cyc = 0;
   int          iss[$];          // cycle numbers of accepted READ issues
   logic [63:0] mq[$];           // FIFO contents, head first
   logic        m_ovf = 1'b0;
   int          m_cnt = 0;

   always @(negedge sys_clk) begin
      int  eff;
      bit  cap;
      bit  pop;
      if (!sys_rst_n) begin
         chk("rst_valid", out_valid, 0);
         chk("rst_data", out_data, 0);
         chk("rst_ovf", overflow, 0);
         chk("rst_cnt", beat_count, 0);
         iss.delete();
         mq.delete();
         m_ovf = 1'b0;
         m_cnt = 0;
      end else begin
         chk("m_valid", out_valid, (mq.size() > 0) ? 1 : 0);
         if (mq.size() > 0) chk("m_data", out_data, mq[0]);
         chk("m_ovf", overflow, m_ovf);
         chk("m_cnt", beat_count, exp_cnt(m_cnt));

         eff = (rd_lat == 3'd0) ? 1 : int'(rd_lat);
         cap = 0;
         foreach (iss[i]) begin
            if (iss[i] >= cyc - eff - (B - 1) && iss[i] <= cyc - eff) cap = 1;
         end
         pop = (mq.size() > 0) && out_ready;
         if (pop) void'(mq.pop_front());
         if (ovf_clr) m_ovf = 1'b0;
         if (cap) begin
            if (mq.size() < D) begin
               mq.push_back({q1, q2});
               m_cnt = (m_cnt + 1) % 65536;
            end else begin
               m_ovf = 1'b1;
            end
         end
         if (read_issue) iss.push_back(cyc);
         while (iss.size() > 0 && iss[0] < cyc - 20) void'(iss.pop_front());
      end
      cyc++;
   end

   // ------------------------------------------------------------------------
   // Stimulus helpers
   // ------------------------------------------------------------------------
   task automatic tick();
      @(posedge sys_clk);
      #1;
      read_issue = 1'b0;
      ovf_clr    = 1'b0;
      q1         = $urandom;
      q2         = $urandom;
   endtask

   task automatic do_reset();
      tick();
      sys_rst_n = 1'b0;
      tick();
      tick();
      sys_rst_n = 1'b1;
   endtask

   typedef struct {
      logic [2:0] lat;
      int         exp_delay;    // cycles from issue to first out_valid
      int         exp_run;      // consecutive entries delivered
   } vec_t;

   vec_t vecs[5];

   initial begin
      int first;
      int last;
      int nvalid;
      int pops;

      vecs[0] = '{lat: 3'd0, exp_delay: 2, exp_run: 4};
      vecs[1] = '{lat: 3'd1, exp_delay: 2, exp_run: 4};
      vecs[2] = '{lat: 3'd3, exp_delay: 4, exp_run: 4};
      vecs[3] = '{lat: 3'd5, exp_delay: 6, exp_run: 4};
      vecs[4] = '{lat: 3'd7, exp_delay: 8, exp_run: 4};

      repeat (3) tick();
      sys_rst_n = 1'b1;

      // ---- latency table, single issue into an empty FIFO, consumer ready
      out_ready = 1'b1;
      foreach (vecs[v]) begin
         repeat (12) tick();
         rd_lat = vecs[v].lat;
         tick();
         read_issue = 1'b1;
         first = -1; last = -1; nvalid = 0;
         for (int k = 1; k <= 20; k++) begin
            tick();
            if (out_valid) begin
               if (first < 0) first = k;
               last = k;
               nvalid++;
            end
         end
         chk($sformatf("lat%0d_delay", vecs[v].lat), first, vecs[v].exp_delay);
         chk($sformatf("lat%0d_run", vecs[v].lat), nvalid, vecs[v].exp_run);
         chk($sformatf("lat%0d_contig", vecs[v].lat), last - first + 1, vecs[v].exp_run);
      end

      // ---- three back-to-back bursts into a stalled FIFO: overflow
      do_reset();
      out_ready = 1'b0;
      rd_lat    = 3'd2;
      tick(); read_issue = 1'b1;               // c
      repeat (4) tick(); read_issue = 1'b1;    // c+4
      repeat (4) tick(); read_issue = 1'b1;    // c+8
      tick();                                  // c+9
      tick();                                  // c+10: 9th beat on the bus
      chk("ovf_before_9th", overflow, 0);
      tick();                                  // c+11
      chk("ovf_after_9th", overflow, 1);
      repeat (9) tick();
      chk("full_valid", out_valid, 1);
      chk("full_cnt", beat_count, exp_cnt(8));
      ovf_clr = 1'b1;
      tick();
      chk("ovf_cleared", overflow, 0);

      // ---- full FIFO, pop on the same edge as a capture
      tick(); read_issue = 1'b1;               // d
      tick();
      tick(); out_ready = 1'b1;                // d+2: first capture cycle
      pops = 0;
      for (int k = 0; k < 40; k++) begin
         if (out_valid) pops++;
         tick();
      end
      chk("full_pop_entries", pops, 12);
      chk("full_pop_ovf", overflow, 0);
      chk("full_pop_cnt", beat_count, exp_cnt(12));

      // ---- reset during the second beat of a burst
      rd_lat = 3'd3;
      tick(); read_issue = 1'b1;               // e
      repeat (4) tick();                       // e+4: first entry presented
      chk("pre_rst_valid", out_valid, 1);
      sys_rst_n = 1'b0;
      #1;
      chk("async_rst_valid", out_valid, 0);
      chk("async_rst_cnt", beat_count, 0);
      tick();
      sys_rst_n = 1'b1;
      repeat (10) tick();
      chk("post_rst_valid", out_valid, 0);
      chk("post_rst_cnt", beat_count, 0);

      // ---- randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         tick();
         read_issue = ($urandom_range(0, 4) == 0);
         out_ready  = ($urandom_range(0, 9) < ((i < 1000) ? 2 : 8));
         if ($urandom_range(0, 63) == 0) ovf_clr = 1'b1;
         if ($urandom_range(0, 99) == 0) rd_lat = 3'($urandom_range(0, 7));
         sys_rst_n = ($urandom_range(0, 499) != 0);
      end
      tick();
      sys_rst_n = 1'b1;
      repeat (20) tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
